// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared types, constants and nibble packing for the sample capture path
//
// Purpose: state encoding, word layout constants and the nibble packing
//          function used by both the capture RTL and any software model.
// Ports:   none (package).

package capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cap_state_e;

   localparam int SAMPLES_PER_WORD = 8;
   localparam int NIBBLE_W         = 4;
   localparam int WORD_W           = SAMPLES_PER_WORD * NIBBLE_W;

   // Places {im, re} into nibble slot 'slot' of 'word'; re sits in the low
   // two bits of the nibble, slot 0 is bits [3:0].
   function automatic logic [WORD_W-1:0] pack_nibble(
      input logic [WORD_W-1:0] word,
      input logic [2:0]        slot,
      input logic [1:0]        re,
      input logic [1:0]        im
   );
      logic [WORD_W-1:0] w;
      w = word;
      w[slot*NIBBLE_W +: NIBBLE_W] = {im, re};
      return w;
   endfunction

endpackage

// File: rtl/sig_capture_if.sv
// rtl/sig_capture_if.sv - host read port of the capture FIFO
//
// Purpose: bundles the host-side read handshake of the capture FIFO.
// Signals: rd_en (host request), rd_data/rd_vld (registered read word),
//          fifo_cnt (words currently held).
// Modports: master = host side, slave = capture block side.

interface sig_capture_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          rd_en;
   logic [31:0]   rd_data;
   logic          rd_vld;
   logic [CW-1:0] fifo_cnt;

   modport master (output rd_en, input rd_data, input rd_vld, input fifo_cnt);
   modport slave  (input rd_en, output rd_data, output rd_vld, output fifo_cnt);

endinterface

// File: rtl/sync_fifo_1r1w.sv
// rtl/sync_fifo_1r1w.sv - single-clock FIFO with registered read and occupancy count
//
// Purpose: word FIFO between the packer and the host read port.
// Ports:   clk, rst (sync active-high), i_flush (empties the FIFO),
//          i_push/i_push_data (write), i_pop (read request),
//          o_rd_data/o_rd_vld (registered read, one cycle after i_pop),
//          o_cnt (occupancy), o_drop (push rejected because full).

module sync_fifo_1r1w #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic [W-1:0]             i_push_data,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rd_data,
   output logic                     o_rd_vld,
   output logic [$clog2(DEPTH):0]   o_cnt,
   output logic                     o_drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_rd_data;
   logic          r_rd_vld;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_empty = (r_cnt == '0);
   assign w_pop   = i_pop && !w_empty && !i_flush;
   // A pop in the same cycle frees the head slot, so a push into a full
   // FIFO still lands.
   assign w_push  = i_push && !i_flush && (!w_full || w_pop);
   assign o_drop  = i_push && !i_flush && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
         r_rd_data <= '0;
         r_rd_vld  <= 1'b0;
      end else if (i_flush) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt    <= '0;
         r_rd_vld <= 1'b0;
      end else begin
         r_rd_vld <= w_pop;
         if (w_pop) begin
            r_rd_data <= r_mem[r_rptr];
            r_rptr    <= r_rptr + AW'(1);
         end
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_rd_vld  = r_rd_vld;
   assign o_cnt     = r_cnt;

endmodule

// File: rtl/sig_capture.sv
// rtl/sig_capture.sv - triggered snapshot recorder for the 2-bit re/im correlator input
//
// Purpose: packs 8 {im,re} sample pairs per 32-bit word after an armed
//          trigger and stores a programmed number of words for host readout.
// Ports:   pclk, reset (sync active-high); smp_re/smp_im/smp_vld sample
//          stream; arm/trig/clear control pulses; cap_len word count
//          (latched on arm, 0 means 1); rd_if host read port (slave);
//          state, ovf (sticky drop flag), done.

module sig_capture
   import capture_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LEN_W = 16
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic [1:0]       smp_re,
   input  logic [1:0]       smp_im,
   input  logic             smp_vld,
   input  logic             arm,
   input  logic             trig,
   input  logic             clear,
   input  logic [LEN_W-1:0] cap_len,
   sig_capture_if.slave     rd_if,
   output logic [1:0]       state,
   output logic             ovf,
   output logic             done
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]       r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_wcnt;
   logic [2:0]       r_slot;
   logic [31:0]      r_word;
   logic             r_ovf;

   logic             w_take;
   logic             w_last;
   logic             w_push;
   logic [31:0]      w_packed;
   logic [LEN_W-1:0] w_wcnt_nxt;
   logic             w_drop;

   // The trigger cycle's own sample is the first one packed.
   assign w_take     = !clear && smp_vld &&
                       ((r_state == S_ARMED && trig) || r_state == S_CAPTURE);
   assign w_last     = (r_slot == 3'(SAMPLES_PER_WORD - 1));
   assign w_push     = w_take && w_last;
   assign w_packed   = pack_nibble(r_word, r_slot, smp_re, smp_im);
   assign w_wcnt_nxt = r_wcnt + LEN_W'(1);

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_len   <= LEN_W'(1);
         r_wcnt  <= '0;
         r_slot  <= '0;
         r_word  <= '0;
         r_ovf   <= 1'b0;
      end else if (clear) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
         r_slot  <= '0;
         r_word  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  r_len   <= (cap_len == '0) ? LEN_W'(1) : cap_len;
                  r_wcnt  <= '0;
                  r_slot  <= '0;
                  r_word  <= '0;
                  r_state <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (trig) begin
                  r_state <= S_CAPTURE;
               end
            end
            default: ;
         endcase
         if (w_take) begin
            if (w_last) begin
               // Dropped words still count toward the length.
               r_word <= '0;
               r_slot <= '0;
               r_wcnt <= w_wcnt_nxt;
               if (w_wcnt_nxt == r_len) begin
                  r_state <= S_DONE;
               end
            end else begin
               r_word <= w_packed;
               r_slot <= r_slot + 3'd1;
            end
         end
      end
   end

   sync_fifo_1r1w #(
      .DEPTH (DEPTH),
      .W     (32)
   ) u_fifo (
      .clk         (pclk),
      .rst         (reset),
      .i_flush     (clear),
      .i_push      (w_push),
      .i_push_data (w_packed),
      .i_pop       (rd_if.rd_en),
      .o_rd_data   (rd_if.rd_data),
      .o_rd_vld    (rd_if.rd_vld),
      .o_cnt       (rd_if.fifo_cnt),
      .o_drop      (w_drop)
   );

   assign state = r_state;
   assign ovf   = r_ovf;
   assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_sig_capture.sv
// tb/tb_sig_capture.sv - scoreboard bench for sig_capture

module tb_sig_capture;
   import capture_pkg::*;

   localparam int DEPTH = 16;
   localparam int LEN_W = 16;

   logic             pclk = 1'b0;
   logic             reset;
   logic [1:0]       smp_re, smp_im;
   logic             smp_vld, arm, trig, clear;
   logic [LEN_W-1:0] cap_len;
   logic [1:0]       state;
   logic             ovf, done;

   sig_capture_if #(.DEPTH(DEPTH)) rd_if ();

   sig_capture #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .pclk    (pclk),
      .reset   (reset),
      .smp_re  (smp_re),
      .smp_im  (smp_im),
      .smp_vld (smp_vld),
      .arm     (arm),
      .trig    (trig),
      .clear   (clear),
      .cap_len (cap_len),
      .rd_if   (rd_if.slave),
      .state   (state),
      .ovf     (ovf),
      .done    (done)
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   // bench model
   logic [31:0] exp_q [$];
   logic [1:0]  m_state;
   int          m_len, m_words, m_cnt;
   logic [2:0]  m_slot;
   logic [31:0] m_word, m_last;
   logic        m_ovf;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, advance model, then compare outputs on the falling edge.
   task automatic cyc(input logic [1:0] re, input logic [1:0] im, input logic vld,
                      input logic trg, input logic rdv, input logic armv, input logic clr,
                      input logic [15:0] len);
      logic take, pop, exp_vld;
      logic [31:0] w;
      smp_re = re; smp_im = im; smp_vld = vld; trig = trg;
      rd_if.rd_en = rdv; arm = armv; clear = clr; cap_len = len;
      take = 1'b0; pop = 1'b0;
      if (clr) begin
         m_state = 2'd0; m_slot = '0; m_word = '0; m_cnt = 0; m_ovf = 1'b0; m_words = 0;
         exp_q.delete();
      end else begin
         pop = rdv && (m_cnt > 0);
         case (m_state)
            2'd0, 2'd3: if (armv) begin
               m_len = (len == 0) ? 1 : int'(len);
               m_words = 0; m_slot = '0; m_word = '0; m_state = 2'd1;
            end
            2'd1: if (trg) begin m_state = 2'd2; take = vld; end
            default: take = vld;
         endcase
         if (take) begin
            w = pack_nibble(m_word, m_slot, re, im);
            if (m_slot == 3'd7) begin
               m_slot = '0; m_word = '0; m_words++;
               if (m_words == m_len) m_state = 2'd3;
               if (m_cnt < DEPTH || pop) begin exp_q.push_back(w); m_cnt++; end
               else m_ovf = 1'b1;
            end else begin
               m_word = w; m_slot = m_slot + 3'd1;
            end
         end
         if (pop) m_cnt--;
      end
      exp_vld = pop;
      @(negedge pclk);
      check_eq("rd_vld", 32'(rd_if.rd_vld), 32'(exp_vld));
      if (exp_vld) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
         end else begin
            w = exp_q.pop_front();
            check_eq("rd_data", rd_if.rd_data, w);
            m_last = w;
         end
      end else begin
         check_eq("rd_data_hold", rd_if.rd_data, m_last);
      end
      check_eq("state", 32'(state), 32'(m_state));
      check_eq("fifo_cnt", 32'(rd_if.fifo_cnt), 32'(m_cnt));
      check_eq("ovf", 32'(ovf), 32'(m_ovf));
      check_eq("done", 32'(done), 32'(m_state == 2'd3));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
   endtask

   task automatic rd(input int n);
      for (int i = 0; i < n; i++) cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
   endtask

   task automatic do_arm(input logic [15:0] len);
      cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, len);
   endtask

   task automatic do_clear();
      cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
   endtask

   // n random valid samples, trigger asserted on the first
   task automatic rnd_samples(input int n, input logic trig_first);
      for (int i = 0; i < n; i++)
         cyc(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1,
             trig_first && (i == 0), 1'b0, 1'b0, 1'b0, 16'd0);
   endtask

   initial begin
      logic [31:0] lw;
      reset = 1'b1; smp_re = '0; smp_im = '0; smp_vld = 1'b0; arm = 1'b0;
      trig = 1'b0; clear = 1'b0; cap_len = '0; rd_if.rd_en = 1'b0;
      m_state = 2'd0; m_len = 1; m_words = 0; m_cnt = 0; m_slot = '0;
      m_word = '0; m_last = '0; m_ovf = 1'b0;
      repeat (3) @(negedge pclk);
      check_eq("rst_state", 32'(state), 32'd0);
      check_eq("rst_rd_data", rd_if.rd_data, 32'd0);
      check_eq("rst_rd_vld", 32'(rd_if.rd_vld), 32'd0);
      check_eq("rst_fifo_cnt", 32'(rd_if.fifo_cnt), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      reset = 1'b0;

      // layout of the package function: k=0..7, re=k, im=~k
      lw = '0;
      for (int k = 0; k < 8; k++) lw = pack_nibble(lw, 3'(k), 2'(k), ~2'(k));
      check_eq("pkg_layout", lw, 32'h369C369C);

      // basic capture: 2 words, ramp pattern
      do_arm(16'd2);
      for (int k = 0; k < 16; k++)
         cyc(2'(k), ~2'(k), 1'b1, k == 0, 1'b0, 1'b0, 1'b0, 16'd0);
      idle(2);
      rd(3);

      // gapped valid, 1 word, re-armed from DONE
      do_arm(16'd1);
      for (int i = 0; i < 16; i++)
         cyc(2'($urandom_range(3)), 2'($urandom_range(3)), (i % 2) == 0, i == 0,
             1'b0, 1'b0, 1'b0, 16'd0);
      idle(1);
      rd(2);

      // overflow: 20 words into 16 slots
      do_clear();
      do_arm(16'd20);
      rnd_samples(160, 1'b1);
      idle(2);
      rd(17);

      // full with a read in the same cycle as the push
      do_clear();
      do_arm(16'd17);
      rnd_samples(128, 1'b1);
      for (int i = 0; i < 8; i++)
         cyc(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1, 1'b0, i == 7,
             1'b0, 1'b0, 16'd0);
      idle(1);
      rd(17);

      // clear mid-capture, then read on empty
      do_clear();
      do_arm(16'd4);
      rnd_samples(5, 1'b1);
      do_clear();
      rd(2);

      // trig in IDLE has no effect
      for (int i = 0; i < 4; i++) cyc(2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);

      // arm pulsed during CAPTURE is ignored
      do_arm(16'd3);
      rnd_samples(4, 1'b1);
      for (int i = 0; i < 20; i++)
         cyc(2'($urandom_range(3)), 2'($urandom_range(3)), 1'b1, 1'b0, 1'b0,
             i % 3 == 0, 1'b0, 16'd1);
      idle(1);
      rd(4);

      // clear wins over arm in the same cycle
      cyc(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);

      // cap_len = 0 captures exactly one word
      do_arm(16'd0);
      rnd_samples(16, 1'b1);
      idle(1);
      rd(2);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
